// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: money width, coin values and the
// change dispenser state encoding.
package vm_pkg;

   localparam int MONEY_W = 3;

   localparam logic [MONEY_W-1:0] COIN1 = 3'd1;
   localparam logic [MONEY_W-1:0] COIN2 = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SELECT   = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_DONE     = 3'd3,
      ST_FAULT    = 3'd4
   } disp_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the vending-stage and hopper signals seen by the change dispenser.
interface change_dispenser_if;
   import vm_pkg::*;

   logic               vend;
   logic [MONEY_W-1:0] change;
   logic               hop2_empty;
   logic               hop1_empty;
   logic               eject_ack;
   logic               eject2;
   logic               eject1;
   logic               busy;
   logic               done;
   logic               fault;
   logic [MONEY_W-1:0] owed;

   modport master (
      output vend, change, hop2_empty, hop1_empty, eject_ack,
      input  eject2, eject1, busy, done, fault, owed
   );

   modport slave (
      input  vend, change, hop2_empty, hop1_empty, eject_ack,
      output eject2, eject1, busy, done, fault, owed
   );

endinterface

// File: rtl/dispense_timer.sv
// Counts cycles while enabled; expired flags the last allowed cycle so the
// owner can leave on the same edge the limit is reached.
module dispense_timer #(
   parameter int ACK_TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && (cnt_q == 8'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change one coin at a time from a 2-unit and a 1-unit hopper,
// preferring 2-unit coins and faulting on an empty hopper or a missing ack.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int ACK_TIMEOUT = 8
) (
   input  logic                clk,
   input  logic                rst,
   change_dispenser_if.slave   bus
);

   disp_state_t        state_q, state_d;
   logic [MONEY_W-1:0] owed_q, owed_d;
   logic [MONEY_W-1:0] coin_q, coin_d;
   logic               in_wait;
   logic               tmr_expired;

   assign in_wait = (state_q == ST_WAIT_ACK);

   // Counter restarts on every ack and stays at zero outside WAIT_ACK.
   dispense_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (!in_wait || bus.eject_ack),
      .enable  (in_wait),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d = state_q;
      owed_d  = owed_q;
      coin_d  = coin_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.vend) begin
               if (bus.change != '0) begin
                  owed_d  = bus.change;
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SELECT: begin
            // A 2-unit coin is only chosen when it cannot overpay.
            if (owed_q == '0) begin
               state_d = ST_DONE;
            end else if (owed_q >= COIN2 && !bus.hop2_empty) begin
               coin_d  = COIN2;
               state_d = ST_WAIT_ACK;
            end else if (!bus.hop1_empty) begin
               coin_d  = COIN1;
               state_d = ST_WAIT_ACK;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_WAIT_ACK: begin
            if (bus.eject_ack) begin
               owed_d  = owed_q - coin_q;
               state_d = ST_SELECT;
            end else if (tmr_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         owed_q  <= '0;
         coin_q  <= '0;
      end else begin
         state_q <= state_d;
         owed_q  <= owed_d;
         coin_q  <= coin_d;
      end
   end

   assign bus.eject2 = in_wait && (coin_q == COIN2);
   assign bus.eject1 = in_wait && (coin_q == COIN1);
   assign bus.busy   = (state_q != ST_IDLE);
   assign bus.done   = (state_q == ST_DONE);
   assign bus.fault  = (state_q == ST_FAULT);
   assign bus.owed   = owed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized transactions for change_dispenser, each checked
// against a greedy coin-payout model computed before the transaction runs.
module tb_change_dispenser;
   import vm_pkg::*;

   localparam int ACK_TO = 8;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   change_dispenser_if bus ();

   change_dispenser #(.ACK_TIMEOUT(ACK_TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_eject2"}, 32'(bus.eject2), 0);
      chk({tag, "_eject1"}, 32'(bus.eject1), 0);
      chk({tag, "_busy"},   32'(bus.busy),   0);
      chk({tag, "_done"},   32'(bus.done),   0);
      chk({tag, "_fault"},  32'(bus.fault),  0);
      chk({tag, "_owed"},   32'(bus.owed),   0);
   endtask

   // Called just after a falling edge; leaves at a falling edge with rst high.
   task automatic do_reset_mid();
      #2;
      rst = 1'b0;
      #1;
      chk_reset_values("async_reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at a falling edge; leaves at the falling edge of the last observed cycle.
   task automatic run_txn(input logic [2:0] chg, input logic h2e, input logic h1e,
                          input int ack_dly, input bit inject);
      logic [2:0] bal;
      logic [2:0] exp_coin[$];
      logic [2:0] exp_bal[$];
      logic [2:0] seen_coin;
      bit         exp_f, finished, prev_ej, ej;
      int         cyc, nseen, hi_cnt, done_cnt, first_req, fault_cyc;

      // Greedy reference: largest coin not exceeding the balance, if stocked.
      bal   = chg;
      exp_f = 1'b0;
      while (bal != 0 && !exp_f) begin
         if (bal >= 2 && !h2e) begin
            exp_coin.push_back(3'd2);
            bal = bal - 3'd2;
            exp_bal.push_back(bal);
         end else if (!h1e) begin
            exp_coin.push_back(3'd1);
            bal = bal - 3'd1;
            exp_bal.push_back(bal);
         end else begin
            exp_f = 1'b1;
         end
      end
      if (ack_dly > ACK_TO && exp_coin.size() > 0) begin
         while (exp_coin.size() > 1) void'(exp_coin.pop_back());
         exp_f = 1'b1;
         bal   = chg;
      end

      bus.hop2_empty = h2e;
      bus.hop1_empty = h1e;
      bus.vend       = 1'b1;
      bus.change     = chg;
      @(negedge clk);
      bus.vend   = 1'b0;
      bus.change = 3'($urandom);

      cyc = 1; nseen = 0; hi_cnt = 0; done_cnt = 0; first_req = 0; fault_cyc = 0;
      prev_ej = 1'b0; finished = 1'b0;
      while (!finished && cyc < 200) begin
         ej = bus.eject2 | bus.eject1;
         if (cyc == 1) chk("busy_after_vend", 32'(bus.busy), 1);
         if (ej && !prev_ej) begin
            if (nseen == 0) first_req = cyc;
            seen_coin = bus.eject2 ? 3'd2 : 3'd1;
            chk("eject_exclusive", 32'(bus.eject2 & bus.eject1), 0);
            if (nseen < exp_coin.size()) chk("coin_value", 32'(seen_coin), 32'(exp_coin[nseen]));
            else chk("unexpected_coin", 1, 0);
            nseen++;
            hi_cnt = 0;
         end
         if (ej) begin
            hi_cnt++;
            if (hi_cnt == ack_dly) bus.eject_ack = 1'b1;
         end else if (bus.eject_ack) begin
            bus.eject_ack = 1'b0;
            if (nseen > 0 && nseen <= exp_bal.size())
               chk("owed_after_ack", 32'(bus.owed), 32'(exp_bal[nseen-1]));
         end
         bus.vend   = inject && (cyc == 3);
         bus.change = (inject && cyc == 3) ? 3'd6 : 3'($urandom);
         if (bus.fault) begin
            fault_cyc = cyc;
            finished  = 1'b1;
         end
         if (bus.done) begin
            done_cnt++;
         end else if (done_cnt > 0) begin
            finished = 1'b1;
            chk("idle_after_done", 32'(bus.busy), 0);
         end
         prev_ej = ej;
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      bus.eject_ack = 1'b0;
      bus.vend      = 1'b0;

      if (!finished) chk("txn_cycle_budget", 0, 1);
      chk("coins_issued", 32'(nseen), 32'(exp_coin.size()));
      chk("done_pulses", 32'(done_cnt), exp_f ? 0 : 1);
      chk("fault_flag", 32'(bus.fault), 32'(exp_f));
      chk("final_owed", 32'(bus.owed), exp_f ? 32'(bal) : 0);
      if (nseen > 0) chk("first_req_latency", 32'(first_req), 2);
      if (exp_f && ack_dly > ACK_TO) chk("timeout_hold", 32'(hi_cnt), ACK_TO);
      if (exp_f && exp_coin.size() == 0) chk("fault_latency", 32'(fault_cyc), 2);
      if (exp_f) chk("fault_ejects_low", 32'(bus.eject2 | bus.eject1), 0);
   endtask

   task automatic post_fault(input logic [2:0] exp_owed);
      bus.vend   = 1'b1;
      bus.change = 3'd3;
      @(negedge clk);
      bus.vend = 1'b0;
      repeat (2) @(negedge clk);
      chk("fault_sticky", 32'(bus.fault), 1);
      chk("fault_owed_frozen", 32'(bus.owed), 32'(exp_owed));
      chk("fault_no_eject", 32'(bus.eject2 | bus.eject1), 0);
      chk("fault_busy", 32'(bus.busy), 1);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rst            = 1'b0;
      bus.vend       = 1'b0;
      bus.change     = '0;
      bus.hop2_empty = 1'b0;
      bus.hop1_empty = 1'b0;
      bus.eject_ack  = 1'b0;

      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      rst = 1'b1;

      run_txn(3'd5, 1'b0, 1'b0, 2, 1'b0);
      run_txn(3'd3, 1'b1, 1'b0, 2, 1'b0);

      run_txn(3'd1, 1'b0, 1'b1, 2, 1'b0);
      post_fault(3'd1);
      do_reset_mid();

      run_txn(3'd4, 1'b0, 1'b0, 99, 1'b0);
      post_fault(3'd4);
      do_reset_mid();

      run_txn(3'd4, 1'b0, 1'b0, ACK_TO, 1'b0);

      // Reset while a coin request is outstanding.
      bus.vend   = 1'b1;
      bus.change = 3'd4;
      @(negedge clk);
      bus.vend = 1'b0;
      repeat (2) @(negedge clk);
      chk("wait_ack_eject2", 32'(bus.eject2), 1);
      do_reset_mid();
      run_txn(3'd0, 1'b0, 1'b0, 1, 1'b0);

      run_txn(3'd7, 1'b0, 1'b0, 3, 1'b1);

      bus.eject_ack = 1'b1;
      @(negedge clk);
      bus.eject_ack = 1'b0;
      chk("stray_ack_busy", 32'(bus.busy), 0);
      chk("stray_ack_owed", 32'(bus.owed), 0);

      for (int i = 0; i < 25; i++) begin
         run_txn(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(1, 9), 1'($urandom_range(0, 1)));
         if (bus.fault === 1'b1) do_reset_mid();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
